// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and default widths for the counter and its sequence checker
package count_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GOOD    = 2'd0,
        RESTART = 2'd1,
        ERROR   = 2'd2
    } step_e;

endpackage

// File: rtl/count_seq_checker_if.sv
// rtl/count_seq_checker_if.sv - sample/control inputs and status outputs of the sequence checker
// master: drives en, count_in, clr; observes status.
// slave : the checker; samples inputs, drives locked, pulses, counters, last_count.
interface count_seq_checker_if #(
    parameter int WIDTH = count_pkg::WIDTH_DEF,
    parameter int CNT_W = count_pkg::CNT_W_DEF
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic             restart_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;
    logic [WIDTH-1:0] last_count;

    modport master (
        output en, count_in, clr,
        input  locked, err_pulse, wrap_pulse, restart_pulse, err_cnt, wrap_cnt, last_count
    );

    modport slave (
        input  en, count_in, clr,
        output locked, err_pulse, wrap_pulse, restart_pulse, err_cnt, wrap_cnt, last_count
    );
endinterface

// File: rtl/step_classify.sv
// rtl/step_classify.sv - combinational classification of one counter step
// i_count : new sample
// i_last  : previous sample
// o_class : GOOD (+1 mod 2^WIDTH), RESTART (jump to 0, not good), ERROR (anything else)
import count_pkg::*;

module step_classify #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_last,
    output step_e            o_class
);
    logic [WIDTH-1:0] w_expected;

    // Truncation to WIDTH makes the all-ones -> 0 wrap a good step.
    assign w_expected = i_last + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        o_class = ERROR;
        if (i_count == w_expected) begin
            o_class = GOOD;
        end else if (i_count == '0) begin
            o_class = RESTART;
        end
    end
endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - monitors a free-running counter for +1 steps, lock, errors, wraps, restarts
// clk : rising-edge clock shared with the counter
// rst : asynchronous active-low reset
// mon : slave side of count_seq_checker_if (en/count_in/clr in; locked, pulses, counters, last_count out)
import count_pkg::*;

module count_seq_checker #(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    count_seq_checker_if.slave   mon
);
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [WIDTH-1:0] ALL_ONES    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_next_state;
    logic [3:0]       r_good_run;
    logic [3:0]       w_next_good_run;
    logic [3:0]       w_good_run_inc;
    step_e            w_class;
    logic             w_has_prev;

    logic             w_err_evt;
    logic             w_wrap_evt;
    logic             w_restart_evt;

    logic             r_err_pulse;
    logic             r_wrap_pulse;
    logic             r_restart_pulse;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_wrap_cnt;
    logic [WIDTH-1:0] r_last_count;

    step_classify #(.WIDTH(WIDTH)) u_step_classify (
        .i_count (mon.count_in),
        .i_last  (r_last_count),
        .o_class (w_class)
    );

    assign w_has_prev     = (r_state != IDLE);
    assign w_good_run_inc = r_good_run + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_good_run <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_good_run <= w_next_good_run;
        end
    end

    // Next-state logic; en=0 holds everything
    always_comb begin
        w_next_state    = r_state;
        w_next_good_run = r_good_run;
        if (mon.en) begin
            case (r_state)
                IDLE: begin
                    w_next_state    = ACQ;
                    w_next_good_run = 4'd0;
                end
                ACQ: begin
                    if (w_class == GOOD) begin
                        w_next_good_run = w_good_run_inc;
                        if (w_good_run_inc == LOCK_TARGET) begin
                            w_next_state = LOCKED;
                        end
                    end else begin
                        w_next_good_run = 4'd0;
                    end
                end
                LOCKED: begin
                    if (w_class != GOOD) begin
                        w_next_state    = ACQ;
                        w_next_good_run = 4'd0;
                    end
                end
                default: begin
                    w_next_state    = IDLE;
                    w_next_good_run = 4'd0;
                end
            endcase
        end
    end

    // Event decode; registered below so every output is flop-driven
    always_comb begin
        w_err_evt     = 1'b0;
        w_wrap_evt    = 1'b0;
        w_restart_evt = 1'b0;
        if (mon.en && w_has_prev) begin
            w_err_evt     = (r_state == LOCKED) && (w_class == ERROR);
            w_restart_evt = (w_class == RESTART);
            w_wrap_evt    = (w_class == GOOD) && (r_last_count == ALL_ONES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_pulse     <= 1'b0;
            r_wrap_pulse    <= 1'b0;
            r_restart_pulse <= 1'b0;
            r_err_cnt       <= '0;
            r_wrap_cnt      <= '0;
            r_last_count    <= '0;
        end else begin
            r_err_pulse     <= w_err_evt;
            r_wrap_pulse    <= w_wrap_evt;
            r_restart_pulse <= w_restart_evt;

            if (mon.en) begin
                r_last_count <= mon.count_in;
            end

            // clr and an event together leave the event counted
            if (mon.clr) begin
                r_err_cnt <= w_err_evt ? CNT_ONE : '0;
            end else if (w_err_evt && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end

            if (mon.clr) begin
                r_wrap_cnt <= w_wrap_evt ? CNT_ONE : '0;
            end else if (w_wrap_evt) begin
                r_wrap_cnt <= r_wrap_cnt + CNT_ONE;
            end
        end
    end

    assign mon.locked        = (r_state == LOCKED);
    assign mon.err_pulse     = r_err_pulse;
    assign mon.wrap_pulse    = r_wrap_pulse;
    assign mon.restart_pulse = r_restart_pulse;
    assign mon.err_cnt       = r_err_cnt;
    assign mon.wrap_cnt      = r_wrap_cnt;
    assign mon.last_count    = r_last_count;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed self-checking bench for count_seq_checker
module tb_count_seq_checker;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_wrap;
    int   exp_err;
    logic [3:0] v;
    logic [3:0] nv;

    count_seq_checker_if #(.WIDTH(4), .CNT_W(8)) mon_if ();

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] val, input logic c);
        @(negedge clk);
        mon_if.en       = e;
        mon_if.count_in = val;
        mon_if.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic lk, input logic ep, input logic wp,
                              input logic rp);
        chk({tag, "_locked"},  {31'd0, mon_if.locked},        {31'd0, lk});
        chk({tag, "_err_p"},   {31'd0, mon_if.err_pulse},     {31'd0, ep});
        chk({tag, "_wrap_p"},  {31'd0, mon_if.wrap_pulse},    {31'd0, wp});
        chk({tag, "_rst_p"},   {31'd0, mon_if.restart_pulse}, {31'd0, rp});
    endtask

    // Good steps from v, tracking expected wraps
    task automatic good_steps(input int n);
        for (int k = 0; k < n; k++) begin
            nv = v + 4'd1;
            if (v == 4'hF) exp_wrap++;
            step(1'b1, nv, 1'b0);
            v = nv;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_err_cnt"},  {24'd0, mon_if.err_cnt},    32'd0);
        chk({tag, "_wrap_cnt"}, {24'd0, mon_if.wrap_cnt},   32'd0);
        chk({tag, "_last"},     {28'd0, mon_if.last_count}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_wrap = 0;
        exp_err = 0;
        rst = 1'b0;
        mon_if.en = 1'b0;
        mon_if.count_in = 4'd0;
        mon_if.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Acquire: 0,1,2 not yet locked; locked after sample of 3
        step(1'b1, 4'd0, 1'b0);
        chk_status("acq0", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        chk_status("acq2", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        chk_status("lock3", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lock3_err_cnt", {24'd0, mon_if.err_cnt}, 32'd0);
        chk("lock3_last", {28'd0, mon_if.last_count}, 32'd3);

        // 4..15 then wrap to 0
        v = 4'd3;
        good_steps(12);
        chk_status("at15", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        v = 4'd0;
        exp_wrap++;
        chk_status("wrap", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_cnt1", {24'd0, mon_if.wrap_cnt}, 32'd1);
        good_steps(1);
        chk_status("post_wrap", 1'b1, 1'b0, 1'b0, 1'b0);

        // Locked at 6, then jump to 9
        good_steps(5);
        chk("at6_last", {28'd0, mon_if.last_count}, 32'd6);
        step(1'b1, 4'd9, 1'b0);
        v = 4'd9;
        chk_status("jump9", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jump9_err_cnt", {24'd0, mon_if.err_cnt}, 32'd1);
        good_steps(2);
        chk_status("relock11", 1'b0, 1'b0, 1'b0, 1'b0);
        good_steps(1);
        chk_status("relock12", 1'b1, 1'b0, 1'b0, 1'b0);

        // 13..15, wrap, 1..7, then counter restarts to 0
        good_steps(11);
        chk("at7_last", {28'd0, mon_if.last_count}, 32'd7);
        chk("wrap_cnt2", {24'd0, mon_if.wrap_cnt}, 32'd2);
        step(1'b1, 4'd0, 1'b0);
        v = 4'd0;
        chk_status("restart", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_err_cnt", {24'd0, mon_if.err_cnt}, 32'd1);

        // Relock, then hold en low for 20 cycles
        good_steps(3);
        chk_status("relock3", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd9, 1'b0);
            chk_status("en_low", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("en_low_last", {28'd0, mon_if.last_count}, 32'd3);
        end
        good_steps(1);
        chk_status("resume4", 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall
        step(1'b1, 4'd4, 1'b0);
        chk_status("stall", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stall_err_cnt", {24'd0, mon_if.err_cnt}, 32'd2);
        exp_err = 2;

        // Drive err_cnt to saturation: relock then a nonzero jump each round
        for (int r = 0; r < 253; r++) begin
            good_steps(3);
            nv = v + 4'd2;
            if (nv == 4'd0) nv = v + 4'd3;
            step(1'b1, nv, 1'b0);
            v = nv;
            exp_err++;
        end
        chk("sat_err_cnt", {24'd0, mon_if.err_cnt}, exp_err);
        chk("sat_wrap_cnt", {24'd0, mon_if.wrap_cnt}, exp_wrap % 256);
        good_steps(3);
        nv = v + 4'd2;
        if (nv == 4'd0) nv = v + 4'd3;
        step(1'b1, nv, 1'b0);
        v = nv;
        chk_status("sat_more", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat_more_cnt", {24'd0, mon_if.err_cnt}, 32'd255);

        // clr together with an error
        good_steps(3);
        nv = v + 4'd2;
        if (nv == 4'd0) nv = v + 4'd3;
        step(1'b1, nv, 1'b1);
        v = nv;
        chk_status("clr_err", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_err_cnt", {24'd0, mon_if.err_cnt}, 32'd1);
        chk("clr_wrap_cnt", {24'd0, mon_if.wrap_cnt}, 32'd0);

        // Asynchronous reset mid-run
        good_steps(3);
        chk_status("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4'd5, 1'b0);
        chk_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_last", {28'd0, mon_if.last_count}, 32'd5);
        chk("post_rst_err", {24'd0, mon_if.err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
